branch_redirect_ctl: RTL and testbench

Sequences the control-flow change that follows a resolved branch in the MEM stage. Takes the taken/not-taken decision from the branch condition logic and the computed target, then:
- holds a redirect request to the fetch unit until it is accepted;
- flushes the wrong-path instructions in IF/ID/EX for a configurable number of cycles;
- stalls the pipeline while doing so.

It sits between the MEM-stage branch condition logic and the fetch/pipeline-control logic.

---
 rtl/branch_redirect_ctl.sv | 176 +++++++++++++++++
 tb/tb_branch_redirect_ctl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctl
//
// Sequences the control-flow change after a branch resolves in MEM. A taken
// branch with a word-aligned target raises a redirect request to fetch, holds
// it until fetch accepts it, then keeps flushing IF/ID/EX for FLUSH_CYCLES
// more cycles. The pipeline is stalled for the whole sequence.
//
// Optional feature: define BRANCH_STATS_EN to build the saturating branch
// statistics counters. Without it, the stat outputs are tied to zero and
// stat_clear_i is ignored.
//
// Parameters:
//   FLUSH_CYCLES      flush cycles after the redirect handshake (0 allowed)
// Ports:
//   clk_i             clock, rising edge
//   rst_i             asynchronous active-high reset
//   br_valid_i        branch resolved in MEM this cycle
//   br_taken_i        branch taken (qualified by br_valid_i)
//   br_target_i       branch target address
//   redirect_ready_i  fetch accepts the redirect
//   stat_clear_i      synchronous clear of the statistics counters
//   redirect_valid_o  redirect request to fetch
//   redirect_pc_o     redirect address, stable while redirect_valid_o is high
//   flush_o           kill IF/ID/EX contents
//   stall_o           hold PC and pipeline registers upstream of MEM
//   misalign_o        one-cycle pulse for a taken, misaligned target
//   busy_o            sequencer not idle
//   stat_total_o      accepted branch count
//   stat_taken_o      accepted taken-branch count
// -----------------------------------------------------------------------------
module branch_redirect_ctl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        br_valid_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        redirect_ready_i,
   input  logic        stat_clear_i,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic        flush_o,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        busy_o,
   output logic [31:0] stat_total_o,
   output logic [31:0] stat_taken_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // A zero-cycle flush still needs a 1-bit counter to keep the logic legal.
   localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [31:0]      pc_r, pc_s;
   logic             misalign_r, misalign_s;

   // Next-state, counter, captured PC and misalign pulse.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      pc_s       = pc_r;
      misalign_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (br_valid_i && br_taken_i) begin
               if (br_target_i[1:0] == 2'b00) begin
                  pc_s    = br_target_i;
                  state_s = REDIRECT;
               end else begin
                  misalign_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         REDIRECT: begin
            if (redirect_ready_i) begin
               if (FLUSH_CYCLES > 0) begin
                  cnt_s   = CNT_LOAD;
                  state_s = FLUSH;
               end else begin
                  cnt_s   = CNT_ZERO;
                  state_s = IDLE;
               end
            end else begin
               state_s = REDIRECT;
            end
         end
         FLUSH: begin
            // The cycle in which the counter reads 1 is the last flush cycle.
            if (cnt_r <= CNT_ONE) begin
               cnt_s   = CNT_ZERO;
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            cnt_s   = CNT_ZERO;
            state_s = IDLE;
         end
      endcase
   end

   // State, counter, captured PC and misalign registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         cnt_r      <= CNT_ZERO;
         pc_r       <= 32'h0000_0000;
         misalign_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         pc_r       <= pc_s;
         misalign_r <= misalign_s;
      end
   end

   // Control outputs decode registered state only, so no input reaches them.
   assign redirect_valid_o = (state_r == REDIRECT);
   assign flush_o          = (state_r == REDIRECT) || (state_r == FLUSH);
   assign stall_o          = (state_r == REDIRECT) || (state_r == FLUSH);
   assign busy_o           = (state_r != IDLE);
   assign redirect_pc_o    = pc_r;
   assign misalign_o       = misalign_r;

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_total_r;
   logic [31:0] stat_taken_r;
   logic        accept_s;

   // Branches arriving outside IDLE are wrong-path and never counted.
   assign accept_s = (state_r == IDLE) && br_valid_i;

   // Saturating statistics counters; clear wins over an increment.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stat_total_r <= 32'h0000_0000;
         stat_taken_r <= 32'h0000_0000;
      end else if (stat_clear_i) begin
         stat_total_r <= 32'h0000_0000;
         stat_taken_r <= 32'h0000_0000;
      end else begin
         if (accept_s && (stat_total_r != 32'hFFFF_FFFF)) begin
            stat_total_r <= stat_total_r + 32'h0000_0001;
         end
         if (accept_s && br_taken_i && (stat_taken_r != 32'hFFFF_FFFF)) begin
            stat_taken_r <= stat_taken_r + 32'h0000_0001;
         end
      end
   end

   assign stat_total_o = stat_total_r;
   assign stat_taken_o = stat_taken_r;
`else
   logic unused_stat_clear_s;

   assign unused_stat_clear_s = stat_clear_i;
   assign stat_total_o        = 32'h0000_0000;
   assign stat_taken_o        = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_branch_redirect_ctl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctl
//
// Two instances share the stimulus: dut0 with FLUSH_CYCLES=2 and dut1 with
// FLUSH_CYCLES=0. Each issued redirect pushes the expected address, redirect
// length and flush length per instance; a monitor measures each flush burst
// and pops the expectation when the burst ends. Misalign pulses are matched
// against a pending-pulse count. Statistics expectations collapse to zero
// when BRANCH_STATS_EN is undefined.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctl;

   logic        clk = 1'b0;
   logic        rst;
   logic        br_valid;
   logic        br_taken;
   logic [31:0] br_target;
   logic        rdy;
   logic        stat_clear;

   logic [1:0]  rv, fl, st, ms, bz;
   logic [31:0] pc0, pc1, tot0, tak0, tot1, tak1;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rv_len;
      logic [31:0] fl_len;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   mis_pend[2];

   always #5 clk = ~clk;

   branch_redirect_ctl #(.FLUSH_CYCLES(2)) dut0 (
      .clk_i(clk), .rst_i(rst), .br_valid_i(br_valid), .br_taken_i(br_taken),
      .br_target_i(br_target), .redirect_ready_i(rdy), .stat_clear_i(stat_clear),
      .redirect_valid_o(rv[0]), .redirect_pc_o(pc0), .flush_o(fl[0]),
      .stall_o(st[0]), .misalign_o(ms[0]), .busy_o(bz[0]),
      .stat_total_o(tot0), .stat_taken_o(tak0)
   );

   branch_redirect_ctl #(.FLUSH_CYCLES(0)) dut1 (
      .clk_i(clk), .rst_i(rst), .br_valid_i(br_valid), .br_taken_i(br_taken),
      .br_target_i(br_target), .redirect_ready_i(rdy), .stat_clear_i(stat_clear),
      .redirect_valid_o(rv[1]), .redirect_pc_o(pc1), .flush_o(fl[1]),
      .stall_o(st[1]), .misalign_o(ms[1]), .busy_o(bz[1]),
      .stat_total_o(tot1), .stat_taken_o(tak1)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] sx(input logic [31:0] v);
`ifdef BRANCH_STATS_EN
      return v;
`else
      return 32'h0000_0000;
`endif
   endfunction

   task automatic expect_redirect(input logic [31:0] pc, input int waits);
      exp_t e;
      e.pc = pc;
      e.rv_len = 32'(waits + 1);
      e.fl_len = 32'(waits + 1 + 2);
      q0.push_back(e);
      e.fl_len = 32'(waits + 1);
      q1.push_back(e);
   endtask

   // Presents one branch, accepted at the next rising edge.
   task automatic branch(input logic taken, input logic [31:0] tgt);
      @(posedge clk); #2;
      br_valid = 1'b1; br_taken = taken; br_target = tgt;
      @(posedge clk); #2;
      br_valid = 1'b0; br_taken = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bz == 2'b00) break;
      end
      check("idle_timeout_busy", {30'h0, bz}, 32'h0);
      @(negedge clk); #1;
   endtask

   task automatic check_stats(input string nm, input logic [31:0] et, input logic [31:0] ek);
      check({nm, "_total0"}, tot0, sx(et));
      check({nm, "_taken0"}, tak0, sx(ek));
      check({nm, "_total1"}, tot1, sx(et));
      check({nm, "_taken1"}, tak1, sx(ek));
   endtask

   task automatic check_all_zero(input string nm);
      check({nm, "_rv"},  {30'h0, rv}, 32'h0);
      check({nm, "_fl"},  {30'h0, fl}, 32'h0);
      check({nm, "_st"},  {30'h0, st}, 32'h0);
      check({nm, "_ms"},  {30'h0, ms}, 32'h0);
      check({nm, "_bz"},  {30'h0, bz}, 32'h0);
      check({nm, "_pc0"}, pc0, 32'h0);
      check({nm, "_pc1"}, pc1, 32'h0);
      check_stats(nm, 32'h0, 32'h0);
   endtask

   // Monitor: measures each flush burst and compares it with the scoreboard.
   initial begin
      int          rv_cnt[2];
      int          fl_cnt[2];
      logic        prev_fl[2];
      logic [31:0] pc_hold[2];
      logic [31:0] pcd;
      exp_t        e;
      for (int d = 0; d < 2; d++) begin
         rv_cnt[d] = 0; fl_cnt[d] = 0; prev_fl[d] = 1'b0; pc_hold[d] = 32'h0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            pcd = (d == 0) ? pc0 : pc1;
            if (rst) begin
               rv_cnt[d] = 0; fl_cnt[d] = 0; prev_fl[d] = 1'b0;
            end else begin
               check($sformatf("stall_eq_flush_dut%0d", d), {31'h0, st[d]}, {31'h0, fl[d]});
               check($sformatf("busy_eq_flush_dut%0d", d), {31'h0, bz[d]}, {31'h0, fl[d]});
               if (rv[d]) begin
                  check($sformatf("rv_implies_flush_dut%0d", d), {31'h0, fl[d]}, 32'h1);
                  if (rv_cnt[d] > 0) check($sformatf("pc_stable_dut%0d", d), pcd, pc_hold[d]);
                  pc_hold[d] = pcd;
                  rv_cnt[d]++;
               end
               if (fl[d]) fl_cnt[d]++;
               if (prev_fl[d] && !fl[d]) begin
                  if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                     checks++; failures++;
                     $display("FAIL unexpected_redirect dut%0d actual_pc=%h expected=none", d, pc_hold[d]);
                  end else begin
                     if (d == 0) e = q0.pop_front();
                     else        e = q1.pop_front();
                     check($sformatf("redirect_pc_dut%0d", d), pc_hold[d], e.pc);
                     check($sformatf("redirect_len_dut%0d", d), 32'(rv_cnt[d]), e.rv_len);
                     check($sformatf("flush_len_dut%0d", d), 32'(fl_cnt[d]), e.fl_len);
                  end
                  rv_cnt[d] = 0; fl_cnt[d] = 0;
               end
               prev_fl[d] = fl[d];
               if (ms[d]) begin
                  checks++;
                  if (mis_pend[d] == 0) begin
                     failures++;
                     $display("FAIL unexpected_misalign dut%0d actual=1 expected=0", d);
                  end else begin
                     mis_pend[d]--;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus.
   initial begin
      mis_pend[0] = 0; mis_pend[1] = 0;
      rst = 1'b1; br_valid = 1'b0; br_taken = 1'b0; br_target = 32'h0;
      rdy = 1'b1; stat_clear = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk); #2;
      rst = 1'b0;

      // Zero-wait handshake.
      expect_redirect(32'h0000_1000, 0);
      branch(1'b1, 32'h0000_1000);
      wait_idle();
      check("pc_hold_idle0", pc0, 32'h0000_1000);
      check("pc_hold_idle1", pc1, 32'h0000_1000);
      check_stats("t1", 32'h1, 32'h1);

      // Four wait states; a branch arriving meanwhile is wrong-path.
      rdy = 1'b0;
      expect_redirect(32'h0000_1000, 4);
      branch(1'b1, 32'h0000_1000);
      br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_2000;
      @(posedge clk); #2;
      br_valid = 1'b0; br_taken = 1'b0;
      repeat (3) @(posedge clk);
      #2 rdy = 1'b1;
      wait_idle();
      check_stats("t2", 32'h2, 32'h2);

      // Clear, then not-taken and misaligned taken: no redirects.
      @(posedge clk); #2 stat_clear = 1'b1;
      @(posedge clk); #2 stat_clear = 1'b0;
      check_stats("clear", 32'h0, 32'h0);
      mis_pend[0] = 1; mis_pend[1] = 1;
      branch(1'b0, 32'h0000_1000);
      branch(1'b1, 32'h0000_0102);
      repeat (3) @(negedge clk);
      #1;
      check("misalign_seen0", 32'(mis_pend[0]), 32'h0);
      check("misalign_seen1", 32'(mis_pend[1]), 32'h0);
      check_stats("t3", 32'h2, 32'h1);

      // Reset while waiting in REDIRECT drops the request.
      rdy = 1'b0;
      branch(1'b1, 32'h0000_0300);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(posedge clk); #2;
      rst = 1'b0; rdy = 1'b1;
      expect_redirect(32'h0000_0040, 0);
      branch(1'b1, 32'h0000_0040);
      wait_idle();
      check_stats("t4", 32'h1, 32'h1);

      // Target 0x80: dut1 exercises the zero flush-cycle build.
      expect_redirect(32'h0000_0080, 0);
      branch(1'b1, 32'h0000_0080);
      wait_idle();

      // Saturation, then clear together with a branch.
`ifdef BRANCH_STATS_EN
      @(negedge clk);
      force dut0.stat_total_r = 32'hFFFF_FFFF;
      force dut0.stat_taken_r = 32'hFFFF_FFFF;
      force dut1.stat_total_r = 32'hFFFF_FFFF;
      force dut1.stat_taken_r = 32'hFFFF_FFFF;
      #1;
      release dut0.stat_total_r;
      release dut0.stat_taken_r;
      release dut1.stat_total_r;
      release dut1.stat_taken_r;
`endif
      expect_redirect(32'h0000_0500, 0);
      branch(1'b1, 32'h0000_0500);
      wait_idle();
      check_stats("sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      expect_redirect(32'h0000_0600, 0);
      @(posedge clk); #2;
      br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0600; stat_clear = 1'b1;
      @(posedge clk); #2;
      br_valid = 1'b0; br_taken = 1'b0; stat_clear = 1'b0;
      check_stats("clr_prio", 32'h0, 32'h0);
      wait_idle();

      check("scoreboard_empty0", 32'(q0.size()), 32'h0);
      check("scoreboard_empty1", 32'(q1.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
